// File: rtl/sha256_msg_loader.sv
// sha256_msg_loader: packs a byte stream big-endian into 32-bit words and loads the sha256_core message buffer.
// Latency: a word is written 1 cycle after the byte that completes it; start pulses 2 cycles after the last byte.
// Backpressure: in_ready drops from the last byte until core_done; en low freezes all state and gates wen/start.
module sha256_msg_loader #(
  parameter int MSG_BUFFER_SIZE = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic [7:0]                         in_byte,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic                               msg_buffer_wen,
  output logic [$clog2(MSG_BUFFER_SIZE)-1:0] write_addr,
  output logic [31:0]                        write_word,
  output logic [63:0]                        msg_size,
  output logic                               start,
  input  logic                               core_done,
  output logic                               busy,
  output logic                               overflow
);

  localparam int          AW         = $clog2(MSG_BUFFER_SIZE);
  localparam logic [61:0] WORD_LIMIT = 62'(MSG_BUFFER_SIZE);

  typedef enum logic [1:0] {
    S_LOAD,
    S_WRITE_LAST,
    S_START,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     byte_cnt_q, byte_cnt_d;
  logic [31:0]     acc_q, acc_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     word_q, word_d;
  logic [63:0]     msg_size_q, msg_size_d;
  logic            start_q, start_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;

  logic            xfer;
  logic [1:0]      lane;
  logic [61:0]     word_idx;
  logic [31:0]     acc_fill;
  logic            ovf_next;

  assign in_ready       = en && (state_q == S_LOAD);
  assign xfer           = in_valid && in_ready;
  assign lane           = byte_cnt_q[1:0];
  assign word_idx       = byte_cnt_q[63:2];
  // Overflow from a previous message is forgotten on the first byte of a new one.
  assign ovf_next       = ((byte_cnt_q == 64'd0) ? 1'b0 : overflow_q) || (word_idx >= WORD_LIMIT);

  // Pending write/start flags survive an en-low stretch and fire once en returns.
  assign msg_buffer_wen = wen_q && en;
  assign start          = start_q && en;
  assign write_addr     = addr_q;
  assign write_word     = word_q;
  assign msg_size       = msg_size_q;
  assign busy           = busy_q;
  assign overflow       = overflow_q;

  // Drop the incoming byte into its big-endian lane of the word being assembled
  always_comb begin
    acc_fill = acc_q;
    case (lane)
      2'd0:    acc_fill[31:24] = in_byte;
      2'd1:    acc_fill[23:16] = in_byte;
      2'd2:    acc_fill[15:8]  = in_byte;
      default: acc_fill[7:0]   = in_byte;
    endcase
  end

  // Next-state logic for the load / write-last / start / wait sequence
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    acc_d      = acc_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    word_d     = word_q;
    msg_size_d = msg_size_q;
    start_d    = 1'b0;
    overflow_d = overflow_q;
    busy_d     = busy_q;

    case (state_q)
      S_LOAD: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 64'd1;
          busy_d     = 1'b1;
          overflow_d = ovf_next;
          if (in_last) begin
            acc_d = 32'd0;
            if (ovf_next) begin
              // Oversized message: drop it silently, no write and no start.
              byte_cnt_d = 64'd0;
              busy_d     = 1'b0;
            end else begin
              // Unfilled lanes are already zero because the accumulator is cleared per word.
              wen_d   = 1'b1;
              addr_d  = word_idx[AW-1:0];
              word_d  = acc_fill;
              state_d = S_WRITE_LAST;
            end
          end else if (lane == 2'd3) begin
            acc_d = 32'd0;
            if (!ovf_next) begin
              wen_d  = 1'b1;
              addr_d = word_idx[AW-1:0];
              word_d = acc_fill;
            end
          end else begin
            acc_d = acc_fill;
          end
        end
      end
      S_WRITE_LAST: begin
        msg_size_d = byte_cnt_q;
        start_d    = 1'b1;
        state_d    = S_START;
      end
      S_START: begin
        state_d = S_WAIT;
      end
      default: begin
        if (core_done) begin
          state_d    = S_LOAD;
          byte_cnt_d = 64'd0;
          busy_d     = 1'b0;
        end
      end
    endcase
  end

  // State registers; everything holds while en is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOAD;
      byte_cnt_q <= 64'd0;
      acc_q      <= 32'd0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      word_q     <= 32'd0;
      msg_size_q <= 64'd0;
      start_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      acc_q      <= acc_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      msg_size_q <= msg_size_d;
      start_q    <= start_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Directed bench for sha256_msg_loader with a 4-word message buffer.
// A negedge monitor records writes, start pulses and transfers; scenario tasks compare against hand-computed values.
module tb_sha256_msg_loader;
  localparam int MBS = 4;

  logic        clk = 1'b0;
  logic        reset, en, in_valid, in_last, core_done;
  logic [7:0]  in_byte;
  logic        in_ready, msg_buffer_wen, start, busy, overflow;
  logic [1:0]  write_addr;
  logic [31:0] write_word;
  logic [63:0] msg_size;

  int errors = 0;
  int checks = 0;
  logic [7:0] msg_mem [0:31];

  int cyc = 0, wr_n = 0, start_n = 0, xfer_n = 0, stall_n = 0, start_cyc = 0, last_xfer_cyc = 0;
  int          wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_cyc  [0:63];

  sha256_msg_loader #(.MSG_BUFFER_SIZE(MBS)) dut (
    .clk(clk), .reset(reset), .en(en), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .msg_buffer_wen(msg_buffer_wen), .write_addr(write_addr), .write_word(write_word),
    .msg_size(msg_size), .start(start), .core_done(core_done), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (msg_buffer_wen && wr_n < 64) begin
      wr_addr[wr_n] = int'(write_addr);
      wr_data[wr_n] = write_word;
      wr_cyc[wr_n]  = cyc;
      wr_n = wr_n + 1;
    end
    if (start) begin
      start_n   = start_n + 1;
      start_cyc = cyc;
    end
    if (in_valid && in_ready && en) begin
      xfer_n = xfer_n + 1;
      if (in_last) last_xfer_cyc = cyc;
    end
    if (in_valid && !in_ready) stall_n = stall_n + 1;
  end

  task automatic send_msg(input int n, input bit with_last);
    bit done_b;
    for (int i = 0; i < n; i++) begin
      done_b   = 1'b0;
      in_valid = 1'b1;
      in_byte  = msg_mem[i];
      in_last  = with_last && (i == n - 1);
      for (int t = 0; t < 50 && !done_b; t++) begin
        @(negedge clk);
        if (in_ready && en) done_b = 1'b1;
        @(posedge clk); #1;
      end
      if (!done_b) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0d not accepted within 50 cycles", i);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (msg_buffer_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b want 0", msg_buffer_wen); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    checks++; if (write_word !== 32'h0) begin errors++; $display("FAIL rst_word: got %h want 0", write_word); end
    checks++; if (write_addr !== 2'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", write_addr); end
    checks++; if (msg_size !== 64'd0) begin errors++; $display("FAIL rst_size: got %0d want 0", msg_size); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_abc();
    int bw, bs;
    bw = wr_n; bs = start_n;
    msg_mem[0] = 8'h61; msg_mem[1] = 8'h62; msg_mem[2] = 8'h63;
    send_msg(3, 1'b1);
    repeat (4) @(posedge clk); #1;
    checks++; if (wr_n - bw !== 1) begin errors++; $display("FAIL abc_nwrites: got %0d want 1", wr_n - bw); end
    checks++; if (wr_addr[bw] !== 0) begin errors++; $display("FAIL abc_addr: got %0d want 0", wr_addr[bw]); end
    checks++; if (wr_data[bw] !== 32'h61626300) begin errors++; $display("FAIL abc_word: got %h want 61626300", wr_data[bw]); end
    checks++; if (wr_cyc[bw] - last_xfer_cyc !== 1) begin errors++; $display("FAIL abc_wr_lat: got %0d want 1", wr_cyc[bw] - last_xfer_cyc); end
    checks++; if (start_n - bs !== 1) begin errors++; $display("FAIL abc_nstart: got %0d want 1", start_n - bs); end
    checks++; if (start_cyc - last_xfer_cyc !== 2) begin errors++; $display("FAIL abc_start_lat: got %0d want 2", start_cyc - last_xfer_cyc); end
    checks++; if (msg_size !== 64'd3) begin errors++; $display("FAIL abc_size: got %0d want 3", msg_size); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abc_busy: got %b want 1", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abc_ready_wait: got %b want 0", in_ready); end
    core_done = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abc_ready_at_done: got %b want 0", in_ready); end
    @(posedge clk); #1;
    core_done = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abc_ready_after_done: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abc_busy_after_done: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int bw, bs, bx, bst, c0;
    for (int i = 0; i < 8; i++) msg_mem[i] = 8'(i);
    bw = wr_n; bs = start_n; bx = xfer_n; bst = stall_n; c0 = cyc;
    send_msg(8, 1'b1);
    checks++; if (cyc - c0 !== 8) begin errors++; $display("FAIL b2b_cycles: got %0d want 8", cyc - c0); end
    checks++; if (stall_n - bst !== 0) begin errors++; $display("FAIL b2b_stalls: got %0d want 0", stall_n - bst); end
    checks++; if (xfer_n - bx !== 8) begin errors++; $display("FAIL b2b_xfers: got %0d want 8", xfer_n - bx); end
    repeat (4) @(posedge clk); #1;
    checks++; if (wr_n - bw !== 2) begin errors++; $display("FAIL b2b_nwrites: got %0d want 2", wr_n - bw); end
    checks++; if (wr_addr[bw] !== 0 || wr_data[bw] !== 32'h00010203) begin errors++; $display("FAIL b2b_w0: got %0d/%h want 0/00010203", wr_addr[bw], wr_data[bw]); end
    checks++; if (wr_addr[bw+1] !== 1 || wr_data[bw+1] !== 32'h04050607) begin errors++; $display("FAIL b2b_w1: got %0d/%h want 1/04050607", wr_addr[bw+1], wr_data[bw+1]); end
    checks++; if (msg_size !== 64'd8) begin errors++; $display("FAIL b2b_size: got %0d want 8", msg_size); end
    checks++; if (start_n - bs !== 1) begin errors++; $display("FAIL b2b_nstart: got %0d want 1", start_n - bs); end
    pulse_done();
  endtask

  task automatic test_overflow();
    int bw, bs, bst;
    for (int i = 0; i < 16; i++) msg_mem[i] = 8'(8'h10 + i);
    bw = wr_n; bs = start_n;
    send_msg(16, 1'b1);
    repeat (4) @(posedge clk); #1;
    checks++; if (wr_n - bw !== 4) begin errors++; $display("FAIL full_nwrites: got %0d want 4", wr_n - bw); end
    checks++; if (wr_data[bw] !== 32'h10111213) begin errors++; $display("FAIL full_w0: got %h want 10111213", wr_data[bw]); end
    checks++; if (wr_addr[bw+3] !== 3 || wr_data[bw+3] !== 32'h1C1D1E1F) begin errors++; $display("FAIL full_w3: got %0d/%h want 3/1c1d1e1f", wr_addr[bw+3], wr_data[bw+3]); end
    checks++; if (start_n - bs !== 1) begin errors++; $display("FAIL full_nstart: got %0d want 1", start_n - bs); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow: got %b want 0", overflow); end
    checks++; if (msg_size !== 64'd16) begin errors++; $display("FAIL full_size: got %0d want 16", msg_size); end
    pulse_done();

    for (int i = 0; i < 17; i++) msg_mem[i] = 8'(8'h20 + i);
    bw = wr_n; bs = start_n; bst = stall_n;
    send_msg(17, 1'b1);
    repeat (3) @(posedge clk); #1;
    checks++; if (wr_n - bw !== 4) begin errors++; $display("FAIL ovf_nwrites: got %0d want 4", wr_n - bw); end
    checks++; if (wr_addr[bw+3] !== 3 || wr_data[bw+3] !== 32'h2C2D2E2F) begin errors++; $display("FAIL ovf_w3: got %0d/%h want 3/2c2d2e2f", wr_addr[bw+3], wr_data[bw+3]); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (start_n - bs !== 0) begin errors++; $display("FAIL ovf_nstart: got %0d want 0", start_n - bs); end
    checks++; if (stall_n - bst !== 0) begin errors++; $display("FAIL ovf_stalls: got %0d want 0", stall_n - bst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready: got %b want 1", in_ready); end
    checks++; if (msg_size !== 64'd16) begin errors++; $display("FAIL ovf_size_held: got %0d want 16", msg_size); end

    msg_mem[0] = 8'hAB;
    bw = wr_n; bs = start_n;
    send_msg(1, 1'b1);
    repeat (4) @(posedge clk); #1;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    checks++; if (wr_n - bw !== 1 || wr_addr[bw] !== 0 || wr_data[bw] !== 32'hAB000000) begin errors++; $display("FAIL ovf_next_write: got n=%0d %0d/%h want 1 0/ab000000", wr_n - bw, wr_addr[bw], wr_data[bw]); end
    checks++; if (start_n - bs !== 1) begin errors++; $display("FAIL ovf_next_start: got %0d want 1", start_n - bs); end
    checks++; if (msg_size !== 64'd1) begin errors++; $display("FAIL ovf_next_size: got %0d want 1", msg_size); end
    pulse_done();
  endtask

  task automatic test_wait_hold();
    int bw, bx, bs;
    msg_mem[0] = 8'h01; msg_mem[1] = 8'h02;
    send_msg(2, 1'b1);
    repeat (3) @(posedge clk); #1;
    bw = wr_n; bx = xfer_n;
    in_valid = 1'b1; in_byte = 8'h55; in_last = 1'b0;
    repeat (10) @(posedge clk); #1;
    checks++; if (xfer_n - bx !== 0) begin errors++; $display("FAIL wait_xfers: got %0d want 0", xfer_n - bx); end
    checks++; if (wr_n - bw !== 0) begin errors++; $display("FAIL wait_writes: got %0d want 0", wr_n - bw); end
    in_valid = 1'b0;
    core_done = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wait_ready_at_done: got %b want 0", in_ready); end
    @(posedge clk); #1;
    core_done = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wait_ready_next: got %b want 1", in_ready); end
    @(posedge clk); #1;

    // core_done arriving mid-message must not disturb the load
    msg_mem[0] = 8'hA0; msg_mem[1] = 8'hA1;
    bw = wr_n; bs = start_n;
    send_msg(2, 1'b0);
    pulse_done();
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL load_done_ignored: got busy=%b rdy=%b want 1/1", busy, in_ready); end
    msg_mem[0] = 8'hA2; msg_mem[1] = 8'hA3; msg_mem[2] = 8'hA4;
    send_msg(3, 1'b1);
    repeat (4) @(posedge clk); #1;
    checks++; if (wr_n - bw !== 2) begin errors++; $display("FAIL load_done_nwrites: got %0d want 2", wr_n - bw); end
    checks++; if (wr_addr[bw] !== 0 || wr_data[bw] !== 32'hA0A1A2A3) begin errors++; $display("FAIL load_done_w0: got %0d/%h want 0/a0a1a2a3", wr_addr[bw], wr_data[bw]); end
    checks++; if (wr_addr[bw+1] !== 1 || wr_data[bw+1] !== 32'hA4000000) begin errors++; $display("FAIL load_done_w1: got %0d/%h want 1/a4000000", wr_addr[bw+1], wr_data[bw+1]); end
    checks++; if (msg_size !== 64'd5 || start_n - bs !== 1) begin errors++; $display("FAIL load_done_size_start: got %0d/%0d want 5/1", msg_size, start_n - bs); end
    pulse_done();
  endtask

  task automatic test_async_reset();
    int bw, bs;
    for (int i = 0; i < 5; i++) msg_mem[i] = 8'(8'h11 + i);
    send_msg(5, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_busy_before: got %b want 1", busy); end
    #3; reset = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
    checks++; if (msg_size !== 64'd0) begin errors++; $display("FAIL arst_size: got %0d want 0", msg_size); end
    checks++; if (write_word !== 32'h0) begin errors++; $display("FAIL arst_word: got %h want 0", write_word); end
    checks++; if (write_addr !== 2'd0 || msg_buffer_wen !== 1'b0 || start !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL arst_flags: got addr=%0d wen=%b start=%b ovf=%b want 0", write_addr, msg_buffer_wen, start, overflow); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    msg_mem[0] = 8'hDE; msg_mem[1] = 8'hAD; msg_mem[2] = 8'hBE; msg_mem[3] = 8'hEF;
    bw = wr_n; bs = start_n;
    send_msg(4, 1'b1);
    repeat (4) @(posedge clk); #1;
    checks++; if (wr_n - bw !== 1 || wr_addr[bw] !== 0 || wr_data[bw] !== 32'hDEADBEEF) begin errors++; $display("FAIL arst_write: got n=%0d %0d/%h want 1 0/deadbeef", wr_n - bw, wr_addr[bw], wr_data[bw]); end
    checks++; if (msg_size !== 64'd4 || start_n - bs !== 1) begin errors++; $display("FAIL arst_size_start: got %0d/%0d want 4/1", msg_size, start_n - bs); end
    pulse_done();
  endtask

  task automatic test_enable_gap();
    int bw, bs;
    for (int i = 0; i < 8; i++) msg_mem[i] = 8'(8'h80 + i);
    bw = wr_n; bs = start_n;
    send_msg(8, 1'b1);
    en = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (wr_n - bw !== 1 || start_n - bs !== 0) begin errors++; $display("FAIL en_low_quiet: got writes=%0d starts=%0d want 1/0", wr_n - bw, start_n - bs); end
    checks++; if (msg_buffer_wen !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL en_low_gates: got wen=%b rdy=%b want 0/0", msg_buffer_wen, in_ready); end
    en = 1'b1;
    repeat (4) @(posedge clk); #1;
    checks++; if (wr_n - bw !== 2) begin errors++; $display("FAIL en_nwrites: got %0d want 2", wr_n - bw); end
    checks++; if (wr_addr[bw+1] !== 1 || wr_data[bw+1] !== 32'h84858687) begin errors++; $display("FAIL en_w1: got %0d/%h want 1/84858687", wr_addr[bw+1], wr_data[bw+1]); end
    checks++; if (wr_cyc[bw+1] - last_xfer_cyc !== 4) begin errors++; $display("FAIL en_wr_delay: got %0d want 4", wr_cyc[bw+1] - last_xfer_cyc); end
    checks++; if (start_n - bs !== 1) begin errors++; $display("FAIL en_nstart: got %0d want 1", start_n - bs); end
    checks++; if (start_cyc - last_xfer_cyc !== 5) begin errors++; $display("FAIL en_start_delay: got %0d want 5", start_cyc - last_xfer_cyc); end
    checks++; if (msg_size !== 64'd8) begin errors++; $display("FAIL en_size: got %0d want 8", msg_size); end
    pulse_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00; core_done = 1'b0;
    test_reset();
    test_abc();
    test_back_to_back();
    test_overflow();
    test_wait_hold();
    test_async_reset();
    test_enable_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_msg_loader.md
Name: sha256_msg_loader

Overview:
Producer side of the sha256_core message-buffer interface. It accepts a byte stream on a valid/ready handshake and packs the bytes big-endian into 32-bit words. It writes each word into the core's message buffer, then supplies the byte count and pulses start. It holds off new input until the core reports done, so an external source such as a UART or DMA can hash messages without a CPU.

Parameters:
MSG_BUFFER_SIZE, 64, depth in words of the sha256_core message buffer; sets write_addr width and the overflow limit.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
en  input  1  global enable; when low, all state holds and in_ready, msg_buffer_wen and start are forced 0
in_byte  input  8  message byte
in_valid  input  1  in_byte valid
in_last  input  1  qualifies in_byte as the final byte of the message
in_ready  output  1  loader accepts a byte this cycle
msg_buffer_wen  output  1  message buffer write enable
write_addr  output  $clog2(MSG_BUFFER_SIZE)  buffer word address
write_word  output  32  packed word
msg_size  output  64  message length in bytes
start  output  1  one-cycle hash start pulse
core_done  input  1  hash-complete pulse from sha256_core
busy  output  1  a message is loading or hashing
overflow  output  1  sticky: last message exceeded the buffer and was not hashed

Behaviour:
- Reset, asynchronous: state=LOAD, all counters 0, msg_size=0, msg_buffer_wen=0, start=0, overflow=0, busy=0, write_word=0, write_addr=0.
- States: LOAD, WRITE_LAST, START, WAIT.
- A byte transfer occurs when in_valid && in_ready && en.
- LOAD:
  - in_ready=1 while en is high.
  - The byte goes into lane byte_cnt[1:0]. Lane 0 is bits 31:24; lane 3 is bits 7:0.
  - byte_cnt is 64 bits and increments on every transfer. word_idx = byte_cnt[63:2].
  - busy=1 from the first transfer of a message.
- Full word: a transfer into lane 3 without in_last completes a word. The next cycle:
  - msg_buffer_wen=1 for exactly one cycle;
  - write_addr = word_idx of that word;
  - write_word = the packed word.
  - The accumulator is cleared to 0.
  - Back-to-back transfers continue with no stall.
- Last byte (transfer with in_last) -> WRITE_LAST. Lanes not yet filled are written as 0x00.
- WRITE_LAST: one cycle.
  - msg_buffer_wen=1 with the final word;
  - in_ready=0;
  - msg_size = final byte_cnt.
  - Then -> START.
- START: one cycle. start=1, then -> WAIT.
- WAIT:
  - in_ready=0;
  - msg_size held stable;
  - busy=1.
  - On core_done: -> LOAD, and byte_cnt is cleared. in_ready returns the cycle after core_done.
- core_done outside WAIT is ignored. A message always has at least 1 byte; a zero-length message is not representable.
- Overflow: a transfer with word_idx >= MSG_BUFFER_SIZE
  - sets overflow and suppresses every write for that word;
  - remaining bytes are still consumed until in_last.
  - On in_last with overflow set, skip WRITE_LAST, START and WAIT: return to LOAD, clear byte_cnt and busy, and issue no start.
  - overflow clears on the first transfer of the next message.
- A word at exactly index MSG_BUFFER_SIZE-1 is legal.
- msg_size is only updated in WRITE_LAST. It holds its value until the next WRITE_LAST.
- en low: registers hold their values. msg_buffer_wen and start are the registered flag ANDed with en, so a pending write or start is issued once when en returns.
- Reset mid-operation clears everything asynchronously. The next message starts at address 0.
- Total latency, from the last-byte transfer: the write is 1 cycle later, start is 2 cycles later.

Test Plan:
1. "abc" (0x61,0x62,0x63, in_last on 0x63): one write addr0=0x61626300; start 2 cycles after the last transfer; msg_size=3; in_ready=0 until core_done.
2. 8 bytes 0x00..0x07 back-to-back: writes addr0=0x00010203 and addr1=0x04050607, with in_ready held 1; msg_size=8; exactly one start pulse.
3. MSG_BUFFER_SIZE=4, 16 bytes: 4 writes and start, no overflow. Then 17 bytes: 4 writes, overflow=1, no start, in_ready stays 1. A following 1-byte message clears overflow and hashes normally.
4. In WAIT, hold in_valid=1 for 10 cycles: no transfers and no writes. After core_done, in_ready=1 on the next cycle. A core_done pulse while in LOAD has no effect.
5. Assert reset asynchronously after 5 bytes: all outputs go 0 immediately. A new 4-byte message 0xDEADBEEF writes addr0=0xDEADBEEF with msg_size=4.
6. Drop en for 3 cycles in the cycle before the last-word write: no wen or start while en is low. When en returns, exactly one write then one start, with correct data.
